instr_mem_sync: RTL
===================

# instr_mem_sync

Synchronous, parametrised byte-addressed instruction memory. It replaces the combinational fetch path of the single-cycle core in pipelined or multi-cycle builds. Fetches are registered, big-endian 32-bit words with a request/valid handshake. A byte-wide loader port lets the testbench or boot logic write a program image. After every reset a built-in clear sequencer zeroes the array.

## Interface
- DEPTH, 1024, memory size in bytes; power of two, ≥ 8
- AW, log2(DEPTH), internal byte-index width (derived; do not override)
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- ready_o  out  1  high once clear sequence is done; fetch/load accepted only when high
- fetch_req_i  in  1  fetch request, sampled on rising edge
- pc_addr_i  in  32  fetch byte address
- instr_o  out  32  fetched word, big-endian
- instr_valid_o  out  1  instr_o updated this cycle (single-cycle pulse per accepted request)
- misalign_o  out  1  accepted fetch had pc_addr_i[1:0] ≠ 0; qualified by instr_valid_o
- oor_o  out  1  accepted fetch had pc_addr_i ≥ DEPTH; qualified by instr_valid_o
- load_we_i  in  1  loader byte write enable
- load_addr_i  in  32  loader byte address
- load_data_i  in  8  loader byte

## Operation
- Storage: DEPTH × 8-bit array; no reset on the array itself.
- FSM states: CLEAR, RUN.
  - rst_n_i low forces CLEAR with clr_cnt = 0.
  - In CLEAR, each edge writes zero to bytes 4·clr_cnt … 4·clr_cnt+3, then increments clr_cnt.
  - When clr_cnt = DEPTH/4−1 is written, go to RUN and set ready_o = 1 on that same edge.
  - RUN is left only by reset.
- In CLEAR:
  - fetch_req_i and load_we_i are ignored.
  - instr_valid_o stays 0.
  - No array write other than the clear writes occurs.
- Fetch (RUN, fetch_req_i = 1):
  - a = pc_addr_i mod DEPTH.
  - instr_o ← {M[a], M[(a+1) mod DEPTH], M[(a+2) mod DEPTH], M[(a+3) mod DEPTH]}. Byte indices wrap at the top of the array.
  - misalign_o ← (pc_addr_i[1:0] ≠ 0). Data is still returned; misalignment is flagged, not blocked.
  - oor_o ← (pc_addr_i[31:AW] ≠ 0).
  - instr_valid_o ← 1.
- No request: instr_valid_o ← 0. instr_o, misalign_o and oor_o hold their last values.
- Load (RUN, load_we_i = 1): M[load_addr_i mod DEPTH] ← load_data_i. Upper address bits are ignored; no flag is raised.
- Simultaneous fetch and load in the same edge: the fetch returns the pre-write contents of every byte (read-before-write). The written byte is visible to fetches accepted on any later edge.
- Reset mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - Any in-flight fetch result is lost.
  - The clear sequence restarts from word 0.

## Timing
- Reset values: ready_o 0, instr_o 32'h0, instr_valid_o 0, misalign_o 0, oor_o 0; FSM in CLEAR, clr_cnt 0.
- Clear duration: DEPTH/4 rising edges after rst_n_i deasserts. With DEPTH = 1024, ready_o rises on the 256th edge.
- Fetch latency: request sampled at edge N produces instr_o and flags valid after edge N+1… precisely, they are registered at edge N, so they are valid during cycle N→N+1.
- Fetch throughput: one per cycle. Back-to-back requests produce back-to-back valid pulses; no bubbles, no backpressure.
- Load: takes effect at the sampling edge. A fetch of that byte sampled at edge N+1 or later sees the new value.
- ready_o is a registered output; the fetch and load ports are usable on the first edge after ready_o reads 1.

## Test plan
- Reset/clear, DEPTH = 1024:
  - Release rst_n_i, hold fetch_req_i = 1 at 0x0 → instr_valid_o = 0 for 256 edges; ready_o rises on edge 256.
  - Next fetch of 0x0 → instr_o = 0x00000000, valid = 1.
- Load then fetch:
  - Load bytes 0x3C,0x08,0x00,0x10 at 0x100–0x103, then fetch 0x100 → instr_o = 0x3C080010 one cycle later, misalign_o = 0, oor_o = 0.
  - Back-to-back fetches 0x100, 0x104 → two consecutive valid cycles.
- Wrap, misalignment and out-of-range:
  - Load 0x11,0x22,0x33,0x44 at 0x3FE, 0x3FF, 0x000, 0x001. Fetch 0x3FE → instr_o = 0x11223344, misalign_o = 1, oor_o = 0.
  - Fetch 0x400 → same bytes as 0x000, oor_o = 1.
- Collision:
  - Byte 0x200 holds 0xAA. In the same cycle, load 0x55 to 0x200 and fetch 0x200 → instr_o[31:24] = 0xAA.
  - Fetch on the next cycle → 0x55.
- Reset mid-operation:
  - Assert rst_n_i low between clock edges during a fetch stream → instr_valid_o and ready_o drop immediately, instr_o = 0.
  - After release, previously loaded 0x3C080010 at 0x100 reads 0x00000000 once ready_o returns.

Source files
------------

// File: rtl/instr_mem_sync.sv
// Synchronous byte-addressed instruction memory with registered big-endian word
// fetch, a byte-wide loader port and a post-reset clear sequencer.
module instr_mem_sync #(
  parameter int DEPTH = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        ready_o,
  input  logic        fetch_req_i,
  input  logic [31:0] pc_addr_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        misalign_o,
  output logic        oor_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [7:0]  load_data_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW - 2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] clr_cnt;
  logic          clr_en;
  logic          fetch_en;
  logic          load_en;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] load_idx;
  logic          unused_load_hi;

  logic [7:0] mem [DEPTH];

  assign fetch_idx      = pc_addr_i[AW-1:0];
  assign load_idx       = load_addr_i[AW-1:0];
  assign unused_load_hi = ^load_addr_i[31:AW];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (clr_en) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // The last clear word is written on the same edge that enters RUN.
  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_cnt == '1) state_next = RUN;
  end

  always_comb begin
    ready_o  = (state == RUN);
    clr_en   = (state == CLEAR);
    fetch_en = ready_o & fetch_req_i;
    load_en  = ready_o & load_we_i;
  end

  // Array has no reset; nonblocking writes give read-before-write on collisions.
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem[{clr_cnt, 2'(k)}] <= '0;
      end
    end
    if (load_en) mem[load_idx] <= load_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
      oor_o         <= 1'b0;
    end else begin
      instr_valid_o <= fetch_en;
      if (fetch_en) begin
        instr_o    <= {mem[fetch_idx], mem[fetch_idx + AW'(1)],
                       mem[fetch_idx + AW'(2)], mem[fetch_idx + AW'(3)]};
        misalign_o <= |pc_addr_i[1:0];
        oor_o      <= |pc_addr_i[31:AW];
      end
    end
  end

endmodule
